// File: rtl/ula_pkg.sv
// Shared constants for the execute-stage ULA controller: ULA op codes, R-type funct codes
// and the multiply/divide sequencer state encoding.
package ula_pkg;

    localparam logic [3:0] AND_OP  = 4'b0000;
    localparam logic [3:0] OR_OP   = 4'b0001;
    localparam logic [3:0] XOR_OP  = 4'b0011;
    localparam logic [3:0] NOR_OP  = 4'b0100;
    localparam logic [3:0] ADD_OP  = 4'b0101;
    localparam logic [3:0] SUB_OP  = 4'b0110;
    localparam logic [3:0] SLTU_OP = 4'b0111;
    localparam logic [3:0] SLT_OP  = 4'b1000;
    localparam logic [3:0] SLL_OP  = 4'b1001;
    localparam logic [3:0] SRL_OP  = 4'b1010;
    localparam logic [3:0] SRA_OP  = 4'b1011;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_t;

endpackage

// File: rtl/ula_ctrl_md_if.sv
// Execute-stage bundle between decoder/register file (master) and the ULA controller (slave).
interface ula_ctrl_md_if #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
);
    logic             valid_i;
    logic [5:0]       func_i;
    logic [WIDTH-1:0] rs_i;
    logic [WIDTH-1:0] rt_i;
    logic [OP_W-1:0]  alu_op_o;
    logic             illegal_o;
    logic             md_sel_o;
    logic [WIDTH-1:0] md_result_o;
    logic             stall_o;
    logic             busy_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output valid_i, func_i, rs_i, rt_i,
        input  alu_op_o, illegal_o, md_sel_o, md_result_o, stall_o, busy_o, hi_o, lo_o
    );

    modport slave (
        input  valid_i, func_i, rs_i, rt_i,
        output alu_op_o, illegal_o, md_sel_o, md_result_o, stall_o, busy_o, hi_o, lo_o
    );
endinterface

// File: rtl/ula_md_seq.sv
// Iterative multiply/divide sequencer owning HI/LO; ULA_MD_EARLY_OUT_EN enables multiply early-out.
// Latency: WIDTH+1 cycles from acceptance to HI/LO write (shorter multiplies with early-out).
// Backpressure: start is honoured only in IDLE; busy tells the caller to hold MD instructions.
module ula_md_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_sgn,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdat,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t          st;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] opa;
    logic [WIDTH-1:0]   opb;
    logic               neg_x;
    logic               neg_r;
    logic               div0;
    logic               op_div;

    logic               rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic               last, mul_done;
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_nx;
    logic [2*WIDTH-1:0] prod_fx;
    logic [WIDTH-1:0]   quo_fx, rem_fx;

    always_comb begin
        rs_neg = is_sgn & rs[WIDTH-1];
        rt_neg = is_sgn & rt[WIDTH-1];
        rs_mag = rs_neg ? -rs : rs;
        rt_mag = rt_neg ? -rt : rt;
        last   = (cnt == CNT_W'(WIDTH-1));
`ifdef ULA_MD_EARLY_OUT_EN
        mul_done = last | (opb[WIDTH-1:1] == '0);
`else
        mul_done = last;
`endif
        // Restoring step: shift next dividend bit into the partial remainder and trial-subtract.
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        rem_diff = rem_sh - {1'b0, opb};
        ge       = (rem_sh >= {1'b0, opb});
        rem_nx   = ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];

        prod_fx = neg_x ? -acc : acc;
        quo_fx  = div0 ? '1 : (neg_x ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        rem_fx  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    assign busy = (st != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
            neg_x  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            op_div <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (start) begin
                        opb    <= rt_mag;
                        opa    <= {{WIDTH{1'b0}}, rs_mag};
                        acc    <= is_div ? {{WIDTH{1'b0}}, rs_mag} : '0;
                        neg_x  <= rs_neg ^ rt_neg;
                        neg_r  <= rs_neg;
                        div0   <= (rt == '0);
                        op_div <= is_div;
                        cnt    <= '0;
                        st     <= is_div ? DIV : MUL;
                    end else begin
                        if (wr_hi) hi <= wdat;
                        if (wr_lo) lo <= wdat;
                    end
                end
                MUL: begin
                    if (opb[0]) acc <= acc + opa;
                    opa <= opa << 1;
                    opb <= opb >> 1;
                    cnt <= cnt + 1'b1;
                    if (mul_done) st <= FIX;
                end
                DIV: begin
                    acc <= {rem_nx, acc[WIDTH-2:0], ge};
                    cnt <= cnt + 1'b1;
                    if (last) st <= FIX;
                end
                FIX: begin
                    if (op_div) begin
                        hi <= rem_fx;
                        lo <= quo_fx;
                    end else begin
                        hi <= prod_fx[2*WIDTH-1:WIDTH];
                        lo <= prod_fx[WIDTH-1:0];
                    end
                    st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ula_ctrl_md.sv
// R-type funct decoder to ULA op code plus mult/div/mfhi/mflo/mthi/mtlo handling (ULA_MD_EARLY_OUT_EN in ula_md_seq).
// Latency: decode combinational; multiply/divide results land in HI/LO WIDTH+1 cycles after acceptance.
// Backpressure: stall_o holds any MD instruction while the sequencer is busy; other functs never stall.
module ula_ctrl_md
    import ula_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         rst,
    ula_ctrl_md_if.slave bus
);

    logic [3:0] op;
    logic       alu_fn, md_fn;
    logic       f_mfhi, f_mflo, f_mthi, f_mtlo, f_mul, f_div, f_sgn;
    logic       busy, issue;
    logic [WIDTH-1:0] hi, lo;

    always_comb begin
        op     = AND_OP;
        alu_fn = 1'b0;
        md_fn  = 1'b0;
        case (bus.func_i)
            F_ADD:            begin op = ADD_OP;  alu_fn = 1'b1; end
            F_SUB:            begin op = SUB_OP;  alu_fn = 1'b1; end
            F_AND:            begin op = AND_OP;  alu_fn = 1'b1; end
            F_OR:             begin op = OR_OP;   alu_fn = 1'b1; end
            F_XOR:            begin op = XOR_OP;  alu_fn = 1'b1; end
            F_NOR:            begin op = NOR_OP;  alu_fn = 1'b1; end
            F_SLT:            begin op = SLT_OP;  alu_fn = 1'b1; end
            F_SLTU:           begin op = SLTU_OP; alu_fn = 1'b1; end
            F_SLL, F_SLLV:    begin op = SLL_OP;  alu_fn = 1'b1; end
            F_SRL, F_SRLV:    begin op = SRL_OP;  alu_fn = 1'b1; end
            F_SRA, F_SRAV:    begin op = SRA_OP;  alu_fn = 1'b1; end
            F_MFHI, F_MTHI, F_MFLO, F_MTLO,
            F_MULT, F_MULTU, F_DIV, F_DIVU: md_fn = 1'b1;
            default: ;
        endcase
    end

    assign f_mfhi = (bus.func_i == F_MFHI);
    assign f_mflo = (bus.func_i == F_MFLO);
    assign f_mthi = (bus.func_i == F_MTHI);
    assign f_mtlo = (bus.func_i == F_MTLO);
    assign f_mul  = (bus.func_i == F_MULT) | (bus.func_i == F_MULTU);
    assign f_div  = (bus.func_i == F_DIV)  | (bus.func_i == F_DIVU);
    assign f_sgn  = (bus.func_i == F_MULT) | (bus.func_i == F_DIV);

    // MD instructions only take effect when the sequencer is idle; otherwise they are held.
    assign issue = bus.valid_i & ~busy;

    ula_md_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (issue & (f_mul | f_div)),
        .is_div (f_div),
        .is_sgn (f_sgn),
        .rs     (bus.rs_i),
        .rt     (bus.rt_i),
        .wr_hi  (issue & f_mthi),
        .wr_lo  (issue & f_mtlo),
        .wdat   (bus.rs_i),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    assign bus.alu_op_o    = OP_W'(op);
    assign bus.illegal_o   = bus.valid_i & ~alu_fn & ~md_fn;
    assign bus.stall_o     = bus.valid_i & md_fn & busy;
    assign bus.busy_o      = busy;
    assign bus.md_sel_o    = issue & (f_mfhi | f_mflo);
    assign bus.md_result_o = (issue & f_mfhi) ? hi : ((issue & f_mflo) ? lo : '0);
    assign bus.hi_o        = hi;
    assign bus.lo_o        = lo;

endmodule
